msg_frame_detector: RTL and testbench



---
 rtl/msg_pkg.sv | 33 +++
 rtl/msg_window.sv | 46 ++++
 rtl/msg_frame_detector.sv | 133 +++++++++++++
 tb/tb_msg_frame_detector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/msg_pkg.sv
// Shared definitions for the message frame detector.
//   - FRAME_A / FRAME_B : the two fixed ASCII frames, index 0 is the first byte on the wire
//   - LEN_A / LEN_B     : frame lengths
//   - WIN_LEN           : comparison window length (longest frame)
//   - state_e           : sync FSM states
//   - frame_class()     : maps the 2-bit select to a frame class (0 = A, 1 = B)
package msg_pkg;

  localparam int LEN_A   = 9;
  localparam int LEN_B   = 7;
  localparam int WIN_LEN = LEN_A;

  // "Guatemala"
  localparam logic [0:LEN_A-1][7:0] FRAME_A = {
    8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61
  };

  // "QQuetza"
  localparam logic [0:LEN_B-1][7:0] FRAME_B = {
    8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61
  };

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // 00/11 select frame A, 01/10 select frame B, so the class is the XOR of the bits.
  function automatic logic frame_class(input logic [1:0] sel);
    return sel[1] ^ sel[0];
  endfunction

endpackage

// File: rtl/msg_window.sv
// Byte window and frame comparators.
//   clk, reset : clock and synchronous active-high reset
//   en_i       : byte valid; the window shifts only when set
//   d_i        : incoming byte
//   hit_a_o    : combinational, d_i completes frame A this cycle (gated by en_i)
//   hit_b_o    : combinational, d_i completes frame B this cycle (gated by en_i)
// The 9-byte comparison window is the 8 stored bytes plus the live d_i, so a
// frame is recognised on the same edge that samples its last byte.
module msg_window
  import msg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [7:0] d_i,
  output logic       hit_a_o,
  output logic       hit_b_o
);

  // Index WIN_LEN-2 holds the most recent stored byte.
  logic [0:WIN_LEN-2][7:0] win_q, win_d;
  logic [0:WIN_LEN-1][7:0] seq;

  assign seq = {win_q, d_i};

  always_comb begin
    win_d = win_q;
    if (en_i) begin
      win_d = {win_q[1:WIN_LEN-2], d_i};
    end
  end

  // Reset to 0x00: that byte occurs in neither frame, so a stale window cannot match.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  // Frame B uses only the newest LEN_B bytes; overlapping prefixes fall out naturally.
  assign hit_a_o = en_i && (seq == FRAME_A);
  assign hit_b_o = en_i && (seq[WIN_LEN-LEN_B:WIN_LEN-1] == FRAME_B);

endmodule

// File: rtl/msg_frame_detector.sv
// Receive-side frame detector for the looping "Guatemala" / "QQuetza" streams.
//   clk, reset : clock and synchronous active-high reset
//   EN         : byte valid, d_in is sampled only when set
//   d_in       : incoming ASCII byte
//   select     : expected frame class (00/11 = A, 01/10 = B)
//   match_a/b  : one-cycle pulse after the edge that sampled the last byte of a frame
//   locked     : high while synchronised to the selected frame
//   err        : one-cycle pulse when a locked frame boundary does not match
//   char_idx   : bytes accepted since the last frame end while locked, 0 in HUNT
//   frame_cnt  : saturating count of accepted selected-frame matches
// Handshake: a byte is transferred on every rising edge with EN=1; there is no
// backpressure. When EN=0 the pulses drop and all other state holds.
module msg_frame_detector
  import msg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic [7:0]       d_in,
  input  logic [1:0]       select,
  output logic             match_a,
  output logic             match_b,
  output logic             locked,
  output logic             err,
  output logic [3:0]       char_idx,
  output logic [CNT_W-1:0] frame_cnt
);

  logic hit_a, hit_b;

  msg_window u_window (
    .clk     (clk),
    .reset   (reset),
    .en_i    (EN),
    .d_i     (d_in),
    .hit_a_o (hit_a),
    .hit_b_o (hit_b)
  );

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ma_q, ma_d;
  logic             mb_q, mb_d;
  logic             cls_q, cls_d;

  logic             sel_cls;
  logic             sel_hit;
  logic [3:0]       last_idx;
  logic [CNT_W-1:0] cnt_inc;

  assign sel_cls  = frame_class(select);
  assign sel_hit  = sel_cls ? hit_b : hit_a;
  assign last_idx = sel_cls ? 4'(LEN_B - 1) : 4'(LEN_A - 1);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cls_d   = cls_q;
    err_d   = 1'b0;
    // hit_x is already gated by EN, so the pulses drop on idle cycles.
    ma_d    = hit_a;
    mb_d    = hit_b;

    if (EN) begin
      cls_d = sel_cls;
      unique case (state_q)
        HUNT: begin
          if (sel_hit) begin
            state_d = LOCKED;
            idx_d   = '0;
            cnt_d   = cnt_inc;
          end
        end
        LOCKED: begin
          // A frame-class switch wins over any boundary result on the same byte.
          if (sel_cls != cls_q) begin
            state_d = HUNT;
            idx_d   = '0;
          end else if (idx_q == last_idx) begin
            idx_d = '0;
            if (sel_hit) begin
              cnt_d = cnt_inc;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end else begin
            // Off-boundary matches do not resynchronise.
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      cnt_q   <= '0;
      cls_q   <= 1'b0;
      err_q   <= 1'b0;
      ma_q    <= 1'b0;
      mb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end

  assign match_a   = ma_q;
  assign match_b   = mb_q;
  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign char_idx  = idx_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_msg_frame_detector.sv
// Scoreboard bench for msg_frame_detector. The driver pushes the expected
// outputs for each edge into exp_q; the monitor pops and compares on the
// following falling edge. A second instance with CNT_W=2 shares the inputs and
// is checked for frame_cnt saturation.
module tb_msg_frame_detector;

  localparam int EXP_W = 16;  // {ma, mb, lk, er, idx[3:0], cnt[7:0]}

  logic       clk;
  logic       reset;
  logic       EN;
  logic [7:0] d_in;
  logic [1:0] select;

  logic       match_a, match_b, locked, err;
  logic [3:0] char_idx;
  logic [7:0] frame_cnt;

  logic       match_a2, match_b2, locked2, err2;
  logic [3:0] char_idx2;
  logic [1:0] frame_cnt2;

  logic [EXP_W-1:0] exp_q[$];
  int checks;
  int failures;
  int cyc;

  logic [7:0] fa [0:8] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};
  logic [7:0] fb [0:6] = '{8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};

  msg_frame_detector #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .EN        (EN),
    .d_in      (d_in),
    .select    (select),
    .match_a   (match_a),
    .match_b   (match_b),
    .locked    (locked),
    .err       (err),
    .char_idx  (char_idx),
    .frame_cnt (frame_cnt)
  );

  msg_frame_detector #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .EN        (EN),
    .d_in      (d_in),
    .select    (select),
    .match_a   (match_a2),
    .match_b   (match_b2),
    .locked    (locked2),
    .err       (err2),
    .char_idx  (char_idx2),
    .frame_cnt (frame_cnt2)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] act;
    logic [1:0]       exp_c2;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {match_a, match_b, locked, err, char_idx, frame_cnt};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got ma=%b mb=%b lk=%b er=%b idx=%0d cnt=%0d want ma=%b mb=%b lk=%b er=%b idx=%0d cnt=%0d",
                   cyc, act[15], act[14], act[13], act[12], act[11:8], act[7:0],
                   e[15], e[14], e[13], e[12], e[11:8], e[7:0]);
        end
        exp_c2 = (e[7:0] > 8'd3) ? 2'd3 : e[1:0];
        checks++;
        if (frame_cnt2 !== exp_c2) begin
          failures++;
          $display("FAIL frame_cnt_w2 cyc=%0d got %0d want %0d", cyc, frame_cnt2, exp_c2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic rst, input logic en, input logic [1:0] sel,
                      input logic [7:0] b, input logic ma, input logic mb,
                      input logic lk, input logic er, input int idx, input int cnt);
    reset  = rst;
    EN     = en;
    select = sel;
    d_in   = b;
    @(posedge clk);
    exp_q.push_back({ma, mb, lk, er, 4'(idx), 8'(cnt)});
    #1;
  endtask

  task automatic do_reset(input logic [1:0] sel);
    step(1'b1, 1'b0, sel, 8'h00, 0, 0, 0, 0, 0, 0);
  endtask

  // Looping frame A from HUNT: lock on byte 9, then a boundary every 9 bytes.
  // With toggle set, each byte is followed by an idle cycle carrying junk.
  task automatic send_a(input int nframes, input bit toggle, input logic [1:0] sel);
    int n, k, ecnt, eidx;
    logic ema, elk;
    for (int f = 0; f < nframes; f++) begin
      for (int j = 0; j < 9; j++) begin
        n = f * 9 + j + 1;
        if (n < 9) begin
          ema = 0; elk = 0; eidx = 0; ecnt = 0;
        end else begin
          k    = (n - 9) % 9;
          ema  = (k == 0);
          elk  = 1;
          eidx = k;
          ecnt = 1 + (n - 9) / 9;
        end
        step(1'b0, 1'b1, sel, fa[j], ema, 0, elk, 0, eidx, ecnt);
        if (toggle) begin
          step(1'b0, 1'b0, sel, 8'($urandom_range(0, 255)), 0, 0, elk, 0, eidx, ecnt);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    EN       = 1'b0;
    d_in     = 8'h00;
    select   = 2'b00;

    // 1: three back-to-back frame A, select=00
    do_reset(2'b00);
    send_a(3, 1'b0, 2'b00);

    // 2: overlapping frame B prefix, select=01
    do_reset(2'b01);
    step(0, 1, 2'b01, 8'h51, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h51, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h51, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h75, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h65, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h74, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h7A, 0, 0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 8'h61, 0, 1, 1, 0, 0, 1);

    // 3: corrupted frame B (7A -> 78) breaks lock, clean frame relocks
    step(0, 1, 2'b01, 8'h51, 0, 0, 1, 0, 1, 1);
    step(0, 1, 2'b01, 8'h51, 0, 0, 1, 0, 2, 1);
    step(0, 1, 2'b01, 8'h75, 0, 0, 1, 0, 3, 1);
    step(0, 1, 2'b01, 8'h65, 0, 0, 1, 0, 4, 1);
    step(0, 1, 2'b01, 8'h74, 0, 0, 1, 0, 5, 1);
    step(0, 1, 2'b01, 8'h78, 0, 0, 1, 0, 6, 1);
    step(0, 1, 2'b01, 8'h61, 0, 0, 0, 1, 0, 1);
    for (int j = 0; j < 6; j++) begin
      step(0, 1, 2'b01, fb[j], 0, 0, 0, 0, 0, 1);
    end
    step(0, 1, 2'b01, fb[6], 0, 1, 1, 0, 0, 2);

    // 4: frame A with EN toggling every cycle
    do_reset(2'b00);
    send_a(2, 1'b1, 2'b00);

    // 5a: lock on A, switch select to 10 mid-frame -> unlock, no err
    do_reset(2'b00);
    send_a(1, 1'b0, 2'b00);
    for (int j = 0; j < 4; j++) begin
      step(0, 1, 2'b00, fa[j], 0, 0, 1, 0, j + 1, 1);
    end
    step(0, 1, 2'b10, fa[4], 0, 0, 0, 0, 0, 1);
    for (int j = 5; j < 8; j++) begin
      step(0, 1, 2'b10, fa[j], 0, 0, 0, 0, 0, 1);
    end
    step(0, 1, 2'b10, fa[8], 1, 0, 0, 0, 0, 1);

    // 5b: same, but 00 -> 11 is the same class, lock holds
    do_reset(2'b00);
    send_a(1, 1'b0, 2'b00);
    for (int j = 0; j < 4; j++) begin
      step(0, 1, 2'b00, fa[j], 0, 0, 1, 0, j + 1, 1);
    end
    for (int j = 4; j < 8; j++) begin
      step(0, 1, 2'b11, fa[j], 0, 0, 1, 0, j + 1, 1);
    end
    step(0, 1, 2'b11, fa[8], 1, 0, 1, 0, 0, 2);

    // 6: reset after byte 5 discards the partial frame; then five frames
    do_reset(2'b00);
    for (int j = 0; j < 5; j++) begin
      step(0, 1, 2'b00, fa[j], 0, 0, 0, 0, 0, 0);
    end
    do_reset(2'b00);
    for (int j = 5; j < 9; j++) begin
      step(0, 1, 2'b00, fa[j], 0, 0, 0, 0, 0, 0);
    end
    send_a(5, 1'b0, 2'b00);

    // drain and report
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
